// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: load/store width codes,
// the ResultSrc encoding that marks a load, and the LSU FSM states.
package riscv_pkg;

    // funct3 access width / signedness
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // ResultSrc value that selects memory read data (identifies a load)
    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_RSP = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables, store-data
// replication, load extraction with sign/zero extension and, when
// MEM_LSU_MISALIGN_TRAP_EN is defined, the misalignment flag.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    output logic        o_misalign,
`endif
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    // Bring the addressed byte/half down to bit 0.
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    // Per-width lane selection; undefined funct3 behaves as a word access.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = w_shifted;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{(i_funct3 == F3_B) & w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_H, F3_HU: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{(i_funct3 == F3_H) & w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_W:    o_be = 4'b1111;
            default: o_be = 4'b1111;
        endcase
    end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    // Half needs an even address, word (and undefined) needs a word address.
    always_comb begin
        o_misalign = (i_addr_lo != 2'b00);
        if (i_funct3 == F3_B || i_funct3 == F3_BU)
            o_misalign = 1'b0;
        else if (i_funct3 == F3_H || i_funct3 == F3_HU)
            o_misalign = i_addr_lo[0];
    end
`endif

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues EX/MEM loads and stores on a
// valid/grant/response bus, stalls the pipeline while an access is
// outstanding, aborts on a wait timeout and registers the MEM/WB outputs.
// Optional: MEM_LSU_MISALIGN_TRAP_EN adds a misalign output and
// suppresses misaligned accesses instead of issuing them word-clipped.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter logic [7:0] MAX_WAIT = 8'd255,
    parameter logic [1:0] LOAD_SRC = RES_LOAD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic        bus_err,
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_next;
    logic [7:0]  r_wait;
    logic        w_mem_op;
    logic        w_issue;
    logic        w_trap;
    logic        w_req;
    logic        w_stall;
    logic        w_timeout;
    logic        w_load_done;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata_ext;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    logic        w_misalign;
`endif

    assign w_mem_op = MemWriteM | (ResultSrcM == LOAD_SRC);

    lsu_align u_align (
        .i_funct3   (funct3M),
        .i_addr_lo  (ALUResultM[1:0]),
        .i_wdata    (WriteDataM),
        .i_rdata    (mem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        .o_misalign (w_misalign),
`endif
        .o_rdata    (w_rdata_ext)
    );

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    // A misaligned op is dropped in IDLE and reported instead of issued.
    assign w_trap   = (r_state == S_IDLE) & w_mem_op & w_misalign;
    assign misalign = w_trap & ~rst;
`else
    assign w_trap = 1'b0;
`endif
    assign w_issue = w_mem_op & ~w_trap;

    // Next state, request, stall and abort decisions for the current cycle.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_timeout    = 1'b0;
        w_load_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_req = 1'b1;
                    if (mem_gnt) begin
                        if (!MemWriteM) begin
                            w_stall      = 1'b1;
                            w_state_next = S_WAIT_RSP;
                        end
                    end else if (r_wait == MAX_WAIT) begin
                        w_timeout = 1'b1;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
            end
            S_WAIT_RSP: begin
                if (mem_rvalid) begin
                    w_load_done  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_wait == MAX_WAIT) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Combinational outputs are forced quiet while reset is held.
    assign mem_req   = w_req & ~rst;
    assign StallM    = w_stall & ~rst;
    assign bus_err   = w_timeout & ~rst;
    assign mem_we    = MemWriteM;
    assign mem_addr  = {ALUResultM[31:2], 2'b00};
    assign mem_be    = MemWriteM ? w_be : 4'b0000;
    assign mem_wdata = w_wdata;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Wait counter: counts stalled cycles within the grant or response phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wait <= 8'd0;
        else if (w_stall && !(w_req && mem_gnt))
            r_wait <= r_wait + 8'd1;
        else
            r_wait <= 8'd0;
    end

    // MEM/WB register: capture when the stage advances, bubble while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            PCPlus4W   <= 32'd0;
            RdW        <= 5'd0;
        end else begin
            if (w_stall) begin
                RegWriteW <= 1'b0;
            end else begin
                RegWriteW  <= RegWriteM & ~w_timeout & ~w_trap;
                ResultSrcW <= ResultSrcM;
                ALUResultW <= ALUResultM;
                PCPlus4W   <= PCPlus4M;
                RdW        <= RdM;
            end
            if (w_load_done)
                ReadDataW <= w_rdata_ext;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu (MAX_WAIT overridden to 4).
module tb_mem_stage_lsu;

    localparam int MAXW = 4;

    logic        clk, rst;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        StallM, bus_err;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_stage_lsu #(.MAX_WAIT(8'd4), .LOAD_SRC(2'b01)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .StallM(StallM), .bus_err(bus_err),
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
    } wb_t;

    wb_t  exp_w;
    logic exp_stall, exp_req, exp_berr, exp_mis;
    int   n_checks, n_fail, op_id;
    logic [3:0]  last_be;
    logic [31:0] last_wdata, last_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Spec-level models of the lane logic.
    function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (!we) return 4'h0;
        case (f3)
            3'b000:  return 4'(1 << off);
            3'b001:  return (off >= 2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return (d & 32'hFF) * 32'h0101_0101;
            3'b001:  return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v, b;
        v = r >> (8 * a[1:0]);
        case (f3)
            3'b000:  begin b = v & 32'hFF;   return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b; end
            3'b100:  return v & 32'hFF;
            3'b001:  begin b = v & 32'hFFFF; return (b >= 32'h8000) ? (b | 32'hFFFF_0000) : b; end
            3'b101:  return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return a[0];
        return a[1:0] != 2'b00;
    endfunction
`endif

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        check("StallM", StallM, exp_stall);
        check("mem_req", mem_req, exp_req);
        check("bus_err", bus_err, exp_berr);
        check("RegWriteW", RegWriteW, exp_w.rw);
        check("ResultSrcW", ResultSrcW, exp_w.rs);
        check("ALUResultW", ALUResultW, exp_w.alu);
        check("ReadDataW", ReadDataW, exp_w.rdata);
        check("PCPlus4W", PCPlus4W, exp_w.pc4);
        check("RdW", RdW, exp_w.rd);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        check("misalign", misalign, exp_mis);
`endif
        if (mem_req) begin
            check("mem_addr", mem_addr, ALUResultM & 32'hFFFF_FFFC);
            check("mem_we", mem_we, MemWriteM);
            check("mem_be", mem_be, model_be(MemWriteM, funct3M, ALUResultM));
            if (MemWriteM) check("mem_wdata", mem_wdata, model_wdata(funct3M, WriteDataM));
        end
    end

    // One instruction through M. Called at posedge+1, returns at posedge+1.
    // gnt_dly: cycles before grant; rsp_dly: cycles after grant until rvalid (99 = never).
    task automatic run_op(input logic rw, input logic we, input logic [1:0] rs, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input int gnt_dly, input int rsp_dly, input logic [31:0] rdata,
                          input logic late_rv, output int stalls, output int berrs, output int mis);
        bit mem_op, trap, done;
        int phase, k, cnt, fin;
        op_id++;
        RegWriteM = rw; MemWriteM = we; ResultSrcM = rs; funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; RdM = rd; PCPlus4M = 32'h100 + 4 * op_id;
        mem_op = we || (rs == 2'b01);
        trap = 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        trap = mem_op && model_misaligned(f3, addr);
`endif
        stalls = 0; berrs = 0; mis = 0; phase = 0; k = 0; cnt = 0; done = 1'b0;
        while (!done) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
            exp_berr = 1'b0; exp_mis = 1'b0;
            if (!mem_op) begin
                exp_req = 1'b0; exp_stall = 1'b0; fin = 0;
                if (late_rv) begin mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; end
            end else if (trap) begin
                exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b1; fin = 2;
            end else if (phase == 0) begin
                exp_req = 1'b1;
                if (k == gnt_dly) begin
                    mem_gnt = 1'b1;
                    if (we) begin exp_stall = 1'b0; fin = 0; end
                    else    begin exp_stall = 1'b1; fin = 4; end
                end else if (cnt == MAXW) begin
                    exp_stall = 1'b0; exp_berr = 1'b1; fin = 2;
                end else begin
                    exp_stall = 1'b1; fin = 3;
                end
            end else begin
                exp_req = 1'b0;
                if (k == rsp_dly) begin
                    mem_rvalid = 1'b1; mem_rdata = rdata; exp_stall = 1'b0; fin = 1;
                end else if (cnt == MAXW) begin
                    exp_stall = 1'b0; exp_berr = 1'b1; fin = 2;
                end else begin
                    exp_stall = 1'b1; fin = 3;
                end
            end
            @(negedge clk);
            if (StallM) stalls++;
            if (bus_err) berrs++;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
            if (misalign) mis++;
`endif
            if (mem_req) begin last_be = mem_be; last_wdata = mem_wdata; last_addr = mem_addr; end
            @(posedge clk);
            case (fin)
                0, 1, 2: begin
                    exp_w.rw  = (fin == 2) ? 1'b0 : rw;
                    exp_w.rs  = rs; exp_w.alu = addr; exp_w.pc4 = PCPlus4M; exp_w.rd = rd;
                    if (fin == 1) exp_w.rdata = model_load(f3, addr, rdata);
                    done = 1'b1;
                end
                3: begin exp_w.rw = 1'b0; cnt++; k++; end
                default: begin exp_w.rw = 1'b0; phase = 1; cnt = 0; k = 1; end
            endcase
            #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        exp_berr = 1'b0; exp_mis = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, be_n, mi;
        n_checks = 0; n_fail = 0; op_id = 0;
        rst = 1'b1;
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; funct3M = 3'b000;
        ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        exp_w = '0; exp_stall = 1'b0; exp_req = 1'b0; exp_berr = 1'b0; exp_mis = 1'b0;
        last_be = '0; last_wdata = '0; last_addr = '0;

        // Reset: a load presented during reset must not request or stall.
        @(posedge clk); #1;
        ResultSrcM = 2'b01; ALUResultM = 32'h0000_0040;
        #1;
        check("rst mem_req", mem_req, 1'b0);
        check("rst StallM", StallM, 1'b0);
        check("rst RegWriteW", RegWriteW, 1'b0);
        check("rst ReadDataW", ReadDataW, 32'd0);
        @(posedge clk); #1;
        ResultSrcM = 2'b00;
        rst = 1'b0;

        // ALU op passes through with one-cycle latency.
        run_op(1, 0, 2'b00, 3'b010, 32'h1234, 0, 5'd5, 0, 0, 0, 0, st, be_n, mi);
        check("alu RdW", RdW, 5'd5);
        check("alu ALUResultW", ALUResultW, 32'h1234);
        check("alu stalls", st, 0);

        // SB to 0x1003, granted at once.
        run_op(0, 1, 2'b00, 3'b000, 32'h1003, 32'hAB, 5'd0, 0, 0, 0, 0, st, be_n, mi);
        check("sb be", last_be, 4'b1000);
        check("sb wdata", last_wdata, 32'hABAB_ABAB);
        check("sb addr", last_addr, 32'h1000);
        check("sb stalls", st, 0);

        // LH to 0x2002, grant after 2 cycles, response 3 cycles later.
        run_op(1, 0, 2'b01, 3'b001, 32'h2002, 0, 5'd7, 2, 3, 32'h8001_0000, 0, st, be_n, mi);
        check("lh stalls", st, 5);
        check("lh ReadDataW", ReadDataW, 32'hFFFF_8001);
        check("lh RegWriteW", RegWriteW, 1'b1);

        // LBU to 0x3001.
        run_op(1, 0, 2'b01, 3'b100, 32'h3001, 0, 5'd8, 0, 1, 32'h0000_F000, 0, st, be_n, mi);
        check("lbu ReadDataW", ReadDataW, 32'h0000_00F0);

        // SW with one-cycle grant delay, SH to the upper half.
        run_op(0, 1, 2'b00, 3'b010, 32'h3008, 32'h1122_3344, 5'd0, 1, 0, 0, 0, st, be_n, mi);
        check("sw be", last_be, 4'b1111);
        check("sw stalls", st, 1);
        run_op(0, 1, 2'b00, 3'b001, 32'h300A, 32'hFFFF_5566, 5'd0, 0, 0, 0, 0, st, be_n, mi);
        check("sh be", last_be, 4'b1100);
        check("sh wdata", last_wdata, 32'h5566_5566);

        // Load whose response never comes: timeout after 4 stalled response cycles.
        run_op(1, 0, 2'b01, 3'b010, 32'h3010, 0, 5'd9, 0, 99, 0, 0, st, be_n, mi);
        check("to stalls", st, 5);
        check("to bus_err pulses", be_n, 1);
        check("to RegWriteW", RegWriteW, 1'b0);

        // Late rvalid with an ALU op in M is ignored.
        run_op(1, 0, 2'b00, 3'b000, 32'h0000_0777, 0, 5'd3, 0, 0, 0, 1, st, be_n, mi);
        check("late ReadDataW", ReadDataW, 32'h0000_00F0);
        check("late stalls", st, 0);

        // LB sign extension proves the FSM is back in IDLE.
        run_op(1, 0, 2'b01, 3'b000, 32'h3003, 0, 5'd10, 0, 2, 32'h8000_0000, 0, st, be_n, mi);
        check("lb ReadDataW", ReadDataW, 32'hFFFF_FF80);

        // Store never granted: timeout after 4 stalled cycles.
        run_op(1, 1, 2'b00, 3'b000, 32'h3000, 32'h5A, 5'd11, 99, 0, 0, 0, st, be_n, mi);
        check("sto stalls", st, 4);
        check("sto bus_err pulses", be_n, 1);
        check("sto RegWriteW", RegWriteW, 1'b0);

        // Misaligned LW to 0x4002.
        run_op(1, 0, 2'b01, 3'b010, 32'h4002, 0, 5'd12, 0, 1, 32'hCAFE_1234, 0, st, be_n, mi);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        check("mis pulses", mi, 1);
        check("mis stalls", st, 0);
        check("mis RegWriteW", RegWriteW, 1'b0);
`else
        check("mis addr", last_addr, 32'h4000);
        check("mis be", last_be, 4'b0000);
        check("mis ReadDataW", ReadDataW, 32'h0000_CAFE);
`endif

        // Reset while waiting for a response.
        RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010;
        ALUResultM = 32'h5000; RdM = 5'd9; PCPlus4M = 32'h0000_0900;
        mem_gnt = 1'b1; exp_req = 1'b1; exp_stall = 1'b1;
        @(posedge clk);
        exp_w.rw = 1'b0;
        #1;
        mem_gnt = 1'b0; exp_req = 1'b0; exp_stall = 1'b1;
        #1;
        rst = 1'b1;
        exp_w = '0; exp_stall = 1'b0; exp_req = 1'b0;
        #1;
        check("mid-rst mem_req", mem_req, 1'b0);
        check("mid-rst StallM", StallM, 1'b0);
        check("mid-rst RegWriteW", RegWriteW, 1'b0);
        check("mid-rst ALUResultW", ALUResultW, 32'd0);
        check("mid-rst RdW", RdW, 5'd0);
        check("mid-rst PCPlus4W", PCPlus4W, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        rst = 1'b0;
        // The pending response shows up after reset and must not be consumed.
        run_op(1, 0, 2'b00, 3'b000, 32'h0000_0ABC, 0, 5'd4, 0, 0, 0, 1, st, be_n, mi);
        check("post-rst ReadDataW", ReadDataW, 32'd0);
        check("post-rst RdW", RdW, 5'd4);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. Consumes the EX/MEM register outputs (…M signals) and executes loads and stores on a valid/grant/response data-memory bus.
- Stalls the pipeline while an access is outstanding.
- Registers the MEM/WB outputs (…W signals), so it is the receiving end of the EX/MEM interface and the driver of the writeback stage.

Parameters:
- MAX_WAIT, 255: cycles allowed in any wait phase before a bus timeout aborts the access; 8-bit counter.
- LOAD_SRC, 2'b01: ResultSrcM encoding that identifies a load.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- RegWriteM  in  1  register write enable of the instruction in M.
- MemWriteM  in  1  store.
- ResultSrcM  in  2  result select; equal to LOAD_SRC means load.
- funct3M  in  3  access width/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ALUResultM  in  32  effective address / ALU result.
- WriteDataM  in  32  store data.
- PCPlus4M  in  32  link value.
- RdM  in  5  destination register.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address {ALUResultM[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- StallM  out  1  hold F/D/E/M stages.
- bus_err  out  1  one-cycle pulse on timeout.
- RegWriteW  out  1  registered MEM/WB output.
- ResultSrcW  out  2  registered MEM/WB output.
- ALUResultW  out  32  registered MEM/WB output.
- ReadDataW  out  32  registered MEM/WB output.
- PCPlus4W  out  32  registered MEM/WB output.
- RdW  out  5  registered MEM/WB output.

Behaviour:
- Reset: state IDLE, wait counter 0. All …W outputs, bus_err and ReadDataW are 0. mem_req=0 and StallM=0 during reset.
- FSM states: IDLE, WAIT_RSP.
- Memory op = MemWriteM | (ResultSrcM==LOAD_SRC). Upstream holds all …M inputs stable while StallM=1.
- IDLE, no memory op: StallM=0. …W registers capture the …M inputs at the next edge (1-cycle latency, like a plain pipeline register).
- IDLE with memory op: mem_req=1 combinationally, and mem_we, mem_addr, mem_be, mem_wdata are driven.
  - Store and mem_gnt: complete. StallM=0, …W capture.
  - Load and mem_gnt: StallM=1, go to WAIT_RSP.
  - No grant: StallM=1, stay in IDLE holding the request.
- WAIT_RSP: mem_req=0. StallM=!mem_rvalid.
  - On mem_rvalid: ReadDataW gets the extracted load data, the other …W capture, return to IDLE.
  - mem_rvalid outside WAIT_RSP is ignored.
- While StallM=1, a bubble goes to W: RegWriteW<=0. The other …W outputs hold.
- Timeout:
  - The counter increments each stalled cycle and clears on completion.
  - On reaching MAX_WAIT: abort, bus_err pulses for 1 cycle, RegWriteW<=0, StallM drops, FSM returns to IDLE.
  - A late mem_rvalid after a timeout is ignored.
- Byte enables by funct3:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'b1111.
  - mem_be is forced 0 for loads (reads return the full word).
- Store data: byte replicated ×4, half ×2, word as-is.
- Load extract: rdata>>(8*addr[1:0]). Sign- or zero-extend per funct3. Undefined funct3 is treated as LW.
- Misaligned access (half with addr[0]=1, word with addr[1:0]!=0), default build: issued word-aligned with mem_be clipped to the addressed word; no split.
- Reset mid-access: the FSM returns to IDLE immediately and mem_req drops asynchronously. A pending response is never consumed.

Optional Feature:
- Macro MEM_LSU_MISALIGN_TRAP_EN adds an output misalign (1 bit).
- Enabled: a misaligned memory op is not issued (mem_req stays 0), misalign pulses 1 cycle, RegWriteW<=0, StallM=0, and the pipeline advances.
- Disabled: the port is absent and the clipped behaviour above applies.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 load/store width constants.
  - ResultSrc encodings, including LOAD_SRC.
  - The FSM state typedef.
- One natural sub-module: lsu_align. It is combinational and produces be, wdata replication, load extraction/extension and the misalign flag. The FSM, counter and …W registers stay in the parent.

Test Plan:
- ALU op (RegWriteM=1, RdM=5, ALUResultM=0x1234), no memory op -> next edge RdW=5, ALUResultW=0x1234, StallM never 1, mem_req=0.
- SB to 0x1003, WriteDataM=0xAB, mem_gnt same cycle -> mem_be=4'b1000, mem_wdata=0xABABABAB, mem_addr=0x1000, zero stall cycles.
- LH to 0x2002, gnt delayed 2 cycles, rvalid 3 cycles later with rdata=0x8001_0000 -> StallM high 5 cycles, ReadDataW=0xFFFF8001, RegWriteW=1 only on the completing edge.
- LBU to 0x3001, rdata=0x0000_F000 -> ReadDataW=0x000000F0.
- Load with no rvalid, MAX_WAIT=4 -> bus_err pulse after 4 stalled cycles, RegWriteW=0, FSM in IDLE; a late rvalid is ignored.
- rst asserted while in WAIT_RSP -> mem_req=0, StallM=0 and all …W outputs 0 immediately. With MEM_LSU_MISALIGN_TRAP_EN, LW to 0x4002 -> misalign pulse and no mem_req.
